// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard scheduler
//
// Contents:
//   state_e      scheduler states RUN / LU_STALL / MEM_WAIT
//   event_e      per-cycle hazard events, encoded so a larger value wins
//   LOAD_LAT_*   legal range of the load-use bubble count
//   PERF_CNT_W   width of the optional performance counter ports
//   pick_event   priority resolution of simultaneous hazard requests
//   clamp_lat    folds an out-of-range LOAD_LAT into the legal range
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // Event encoding doubles as the priority rank: memory wait > branch > load-use > jump.
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_JUMP     = 3'd1,
    EV_LOAD_USE = 3'd2,
    EV_BRANCH   = 3'd3,
    EV_MEM_WAIT = 3'd4
  } event_e;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 3;
  localparam int PERF_CNT_W   = 32;

  function automatic event_e pick_event(logic mem_wait, logic branch, logic load_use, logic jump);
    if (mem_wait) return EV_MEM_WAIT;
    else if (branch) return EV_BRANCH;
    else if (load_use) return EV_LOAD_USE;
    else if (jump) return EV_JUMP;
    else return EV_NONE;
  endfunction

  function automatic int clamp_lat(int lat);
    if (lat < LOAD_LAT_MIN) return LOAD_LAT_MIN;
    else if (lat > LOAD_LAT_MAX) return LOAD_LAT_MAX;
    else return lat;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - combinational load-use register comparator
//
// Ports:
//   rd        destination register of the producing load
//   rs1, rs2  source registers of the consuming instruction
//   uses_rs2  consumer actually reads rs2
//   match_a   rs1 depends on rd
//   match_b   rs2 depends on rd
// Register $0 is hard-wired to zero, so it never creates a dependency.
module hazard_cmp #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs2,
  output logic             match_a,
  output logic             match_b
);

  logic rd_nz;

  assign rd_nz   = |rd;
  assign match_a = rd_nz && (rd == rs1);
  assign match_b = rd_nz && uses_rs2 && (rd == rs2);

endmodule

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - 5-stage pipeline hazard scheduler (load-use, branch, jump, memory wait)
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2/id_uses_rs2, id_jump     ID-stage operand and jump info
//   ex_mem_read/ex_write_addr/ex_branch_taken  EX-stage load and branch info
//   mem_req, mem_ready      MEM-stage access handshake
//   pc_write, ifid_write, ifid_flush       front-end control
//   idex_flush, hazard_a, hazard_b         ID/EX bubble insertion and operand match
//   pipe_hold               ID/EX and EX/MEM hold during a memory wait
//   stall_cnt, flush_cnt, memwait_cnt      present only with HAZARD_PERF_CNT_EN
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_addr,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic             pipe_hold
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
  output logic [PERF_CNT_W-1:0] memwait_cnt
`endif
);

  localparam int         LAT       = clamp_lat(LOAD_LAT);
  localparam logic [1:0] BCNT_INIT = 2'(LAT - 1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;     // state to resume once a memory wait ends
  state_e           eff;              // state whose rules apply this cycle
  logic [1:0]       bcnt_q, bcnt_d;
  logic [REG_W-1:0] lu_rd_q, lu_rd_d;
  logic [REG_W-1:0] cmp_rd;
  logic             started_q;        // first edge after release only arms decode
  logic             match_a, match_b;
  logic             mem_wait, load_use;
  event_e           ev;

  // A cycle in MEM_WAIT where the access completes behaves as the pre-wait state.
  assign eff      = (state_q == MEM_WAIT) ? ret_q : state_q;
  assign cmp_rd   = (eff == LU_STALL) ? lu_rd_q : ex_write_addr;
  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (match_a | match_b);

  hazard_cmp #(.REG_W(REG_W)) u_cmp (
    .rd       (cmp_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .uses_rs2 (id_uses_rs2),
    .match_a  (match_a),
    .match_b  (match_b)
  );

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    bcnt_d     = bcnt_q;
    lu_rd_d    = lu_rd_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    hazard_a   = 1'b0;
    hazard_b   = 1'b0;
    pipe_hold  = 1'b0;

    // Branch, load-use and jump are only decoded in RUN; LU_STALL has a bubble in EX.
    ev = pick_event(mem_wait,
                    (eff == RUN) && ex_branch_taken,
                    (eff == RUN) && load_use,
                    (eff == RUN) && id_jump);

    unique case (ev)
      EV_MEM_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
        state_d    = MEM_WAIT;
        ret_d      = eff;
      end
      EV_BRANCH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = RUN;
      end
      EV_LOAD_USE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        hazard_a   = match_a;
        hazard_b   = match_b;
        if (LAT == 1) begin
          state_d = RUN;
        end else begin
          bcnt_d  = BCNT_INIT;
          lu_rd_d = ex_write_addr;
          state_d = LU_STALL;
        end
      end
      EV_JUMP: begin
        ifid_flush = 1'b1;
        state_d    = RUN;
      end
      default: begin
        if (eff == LU_STALL) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          hazard_a   = match_a;
          hazard_b   = match_b;
          bcnt_d     = bcnt_q - 2'd1;
          state_d    = (bcnt_q == 2'd1) ? RUN : LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
    endcase

    // Reset and the arming cycle after release squash the whole pipe front.
    if (!reset || !started_q) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      hazard_a   = 1'b0;
      hazard_b   = 1'b0;
      pipe_hold  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      bcnt_q    <= 2'd0;
      lu_rd_q   <= '0;
      started_q <= 1'b0;
    end else if (!started_q) begin
      started_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bcnt_q  <= bcnt_d;
      lu_rd_q <= lu_rd_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = PERF_CNT_W'(1);

  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (!pc_write) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (ifid_flush || idex_flush) flush_cnt_d = flush_cnt_q + CNT_ONE;
    if (state_q == MEM_WAIT) memwait_cnt_d = memwait_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else if (started_q) begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - self-checking bench for hazard_sched at LOAD_LAT 1 and 3
module tb_hazard_sched;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_write_addr;
  logic       id_uses_rs2, id_jump, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

  logic pc_write0, ifid_write0, ifid_flush0, idex_flush0, hazard_a0, hazard_b0, pipe_hold0;
  logic pc_write1, ifid_write1, ifid_flush1, idex_flush1, hazard_a1, hazard_b1, pipe_hold1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt0, flush_cnt0, memwait_cnt0;
  logic [31:0] stall_cnt1, flush_cnt1, memwait_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: remaining stall cycles and the load destination being waited on.
  bit         m_started [2];
  int         m_left    [2];
  logic [4:0] m_rd      [2];
  int         m_lat     [2];

  int stall0, stall1, hold0, hold1;

  hazard_sched #(.LOAD_LAT(1), .REG_W(5)) u_lat1 (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write0), .ifid_write(ifid_write0), .ifid_flush(ifid_flush0),
    .idex_flush(idex_flush0), .hazard_a(hazard_a0), .hazard_b(hazard_b0), .pipe_hold(pipe_hold0)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0), .memwait_cnt(memwait_cnt0)
`endif
  );

  hazard_sched #(.LOAD_LAT(3), .REG_W(5)) u_lat3 (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_flush(idex_flush1), .hazard_a(hazard_a1), .hazard_b(hazard_b1), .pipe_hold(pipe_hold1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .memwait_cnt(memwait_cnt1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output vector order: pc_write ifid_write ifid_flush idex_flush hazard_a hazard_b pipe_hold
  function automatic logic [6:0] model_eval(input int idx, output bit n_started,
                                            output int n_left, output logic [4:0] n_rd);
    logic ha, hb;
    n_started = reset;
    n_left    = m_left[idx];
    n_rd      = m_rd[idx];
    if (!reset || !m_started[idx]) begin
      n_left = 0;
      n_rd   = 5'd0;
      return 7'b0011000;
    end
    if (mem_req && !mem_ready) return 7'b0000001;
    if (m_left[idx] > 0) begin
      ha     = (m_rd[idx] == id_rs1);
      hb     = id_uses_rs2 && (m_rd[idx] == id_rs2);
      n_left = m_left[idx] - 1;
      return {4'b0001, ha, hb, 1'b0};
    end
    if (ex_branch_taken) return 7'b1111000;
    ha = ex_mem_read && (ex_write_addr != 5'd0) && (ex_write_addr == id_rs1);
    hb = ex_mem_read && (ex_write_addr != 5'd0) && id_uses_rs2 && (ex_write_addr == id_rs2);
    if (ha || hb) begin
      n_left = m_lat[idx] - 1;
      n_rd   = ex_write_addr;
      return {4'b0001, ha, hb, 1'b0};
    end
    if (id_jump) return 7'b1110000;
    return 7'b1100000;
  endfunction

  // Inputs are set just after a rising edge; outputs are sampled mid-cycle.
  task automatic step(input string tag);
    logic [6:0] e0, e1;
    bit         ns0, ns1;
    int         nl0, nl1;
    logic [4:0] nr0, nr1;
    #4;
    e0 = model_eval(0, ns0, nl0, nr0);
    e1 = model_eval(1, ns1, nl1, nr1);
    check({tag, "/lat1"}, 32'({pc_write0, ifid_write0, ifid_flush0, idex_flush0,
                               hazard_a0, hazard_b0, pipe_hold0}), 32'(e0));
    check({tag, "/lat3"}, 32'({pc_write1, ifid_write1, ifid_flush1, idex_flush1,
                               hazard_a1, hazard_b1, pipe_hold1}), 32'(e1));
    if (!pc_write0) stall0++;
    if (!pc_write1) stall1++;
    if (pipe_hold0) hold0++;
    if (pipe_hold1) hold1++;
    @(posedge clock);
    m_started[0] = ns0; m_left[0] = nl0; m_rd[0] = nr0;
    m_started[1] = ns1; m_left[1] = nl1; m_rd[1] = nr1;
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; id_jump = 1'b0;
    ex_mem_read = 1'b0; ex_write_addr = 5'd0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic zero_counts();
    stall0 = 0; stall1 = 0; hold0 = 0; hold1 = 0;
  endtask

  initial begin
    m_lat[0] = 1; m_lat[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 1'b0; m_left[i] = 0; m_rd[i] = 5'd0;
    end
    clear_inputs();
    reset = 1'b0;
    zero_counts();
    @(posedge clock); #1;
    step("reset");
    reset = 1'b1;
    step("release");
    step("idle");

    // Load-use on rs1, rd=5
    zero_counts();
    ex_mem_read = 1'b1; ex_write_addr = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
    step("lu_rs1_detect");
    ex_mem_read = 1'b0;
    for (int i = 0; i < 3; i++) step("lu_rs1_after");
    check("lu_rs1_stalls_lat1", 32'(stall0), 32'd1);
    check("lu_rs1_stalls_lat3", 32'(stall1), 32'd3);

    // Load-use on rs2, rd=7
    zero_counts();
    ex_mem_read = 1'b1; ex_write_addr = 5'd7; id_rs1 = 5'd2; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    step("lu_rs2_detect");
    ex_mem_read = 1'b0;
    for (int i = 0; i < 3; i++) step("lu_rs2_after");
    check("lu_rs2_stalls_lat3", 32'(stall1), 32'd3);

    // $0 and unused operand never stall
    zero_counts();
    ex_mem_read = 1'b1; ex_write_addr = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    step("rd_zero");
    ex_write_addr = 5'd4; id_rs1 = 5'd1; id_rs2 = 5'd4; id_uses_rs2 = 1'b0;
    step("rs2_unused");
    check("no_stall_lat3", 32'(stall1), 32'd0);
    ex_mem_read = 1'b0;

    // Memory wait arriving in LU_STALL with two bubbles left
    zero_counts();
    ex_mem_read = 1'b1; ex_write_addr = 5'd6; id_rs1 = 5'd6; id_uses_rs2 = 1'b0;
    step("mw_lu_detect");
    ex_mem_read = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("mw_wait");
    mem_ready = 1'b1;
    step("mw_release");
    mem_req = 1'b0; mem_ready = 1'b0;
    step("mw_resume");
    step("mw_run");
    check("mw_holds_lat1", 32'(hold0), 32'd4);
    check("mw_holds_lat3", 32'(hold1), 32'd4);
    check("mw_stalls_lat3", 32'(stall1), 32'd7);

    // Branch beats load-use and jump
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_write_addr = 5'd3; id_rs1 = 5'd3; id_jump = 1'b1;
    step("branch_prio");
    clear_inputs();
    id_jump = 1'b1;
    step("jump");
    id_jump = 1'b0;
    step("post_jump");

    // Asynchronous reset in the middle of MEM_WAIT
    ex_mem_read = 1'b1; ex_write_addr = 5'd2; id_rs1 = 5'd2;
    step("rst_lu");
    ex_mem_read = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    step("rst_wait");
    reset = 1'b0;
    #1;
`ifdef HAZARD_PERF_CNT_EN
    check("cnt_stall_rst", stall_cnt1, 32'd0);
    check("cnt_flush_rst", flush_cnt1, 32'd0);
    check("cnt_memwait_rst", memwait_cnt1, 32'd0);
`endif
    step("rst_low");
    step("rst_low2");
    reset = 1'b1; mem_req = 1'b0;
    step("rst_release");
    step("rst_run");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_write_addr   = 5'($urandom_range(0, 7));
      ex_mem_read     = ($urandom_range(0, 9) < 4);
      ex_branch_taken = ($urandom_range(0, 9) < 2);
      id_jump         = ($urandom_range(0, 9) < 2);
      mem_req         = ($urandom_range(0, 9) < 3);
      mem_ready       = 1'($urandom_range(0, 1));
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
